// File: rtl/simplerisc_pkg.sv
// SimpleRisc shared definitions: opcode values and instruction field positions.
package simplerisc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_CMP  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOT  = 5'd8,
    OP_MOV  = 5'd9,
    OP_LSL  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_NOP  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_BEQ  = 5'd16,
    OP_BGT  = 5'd17,
    OP_B    = 5'd18,
    OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_t;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 22;
  localparam int RS1_HI  = 21;
  localparam int RS1_LO  = 18;
  localparam int RS2_HI  = 17;
  localparam int RS2_LO  = 14;

  localparam logic [3:0] RA_IDX = 4'd15;

endpackage

// File: rtl/of_src_decode.sv
// Operand-use decode: which sources an OF instruction reads and what it writes.
module of_src_decode
  import simplerisc_pkg::*;
(
  input  logic [31:0] instruction,
  output logic        rd_rs1,
  output logic        rd_rs2,
  output logic        rd_rd,
  output logic        rd_ra,
  output logic        rd_flags,
  output logic        wr_reg,
  output logic [3:0]  wr_idx,
  output logic        wr_flags
);

  logic [4:0] opc;
  logic       imm;
  logic       unused_lsb;

  assign opc        = instruction[OPC_HI:OPC_LO];
  assign imm        = instruction[IMM_BIT];
  assign unused_lsb = ^instruction[RS1_HI:0];

  // Classify the opcode into register/flag read and write usage.
  always_comb begin
    rd_rs1   = 1'b0;
    rd_rs2   = 1'b0;
    rd_rd    = 1'b0;
    rd_ra    = 1'b0;
    rd_flags = 1'b0;
    wr_reg   = 1'b0;
    wr_flags = 1'b0;
    wr_idx   = instruction[RD_HI:RD_LO];
    case (opc)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR: begin
        rd_rs1 = 1'b1;
        rd_rs2 = ~imm;
        wr_reg = 1'b1;
      end
      OP_CMP: begin
        rd_rs1   = 1'b1;
        rd_rs2   = ~imm;
        wr_flags = 1'b1;
      end
      OP_NOT, OP_MOV: begin
        rd_rs2 = ~imm;
        wr_reg = 1'b1;
      end
      OP_LD: begin
        rd_rs1 = 1'b1;
        wr_reg = 1'b1;
      end
      // store data comes from the rd field
      OP_ST: begin
        rd_rs1 = 1'b1;
        rd_rd  = 1'b1;
      end
      OP_BEQ, OP_BGT: rd_flags = 1'b1;
      OP_CALL: begin
        wr_reg = 1'b1;
        wr_idx = RA_IDX;
      end
      OP_RET: rd_ra = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/of_scoreboard.sv
// Register/flags scoreboard for the OF stage: RAW/WAW interlock, occupancy and stall stats.
module of_scoreboard
  import simplerisc_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instruction_in,
  input  logic                   inst_valid,
  input  logic                   flush,
  input  logic [3:0]             wr_adr,
  input  logic                   is_wb,
  input  logic                   flags_wb,
  output logic                   stall,
  output logic                   issue,
  output logic [15:0]            pending,
  output logic                   flags_pending,
  output logic                   busy,
  output logic                   wb_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic       rd_rs1, rd_rs2, rd_rd, rd_ra, rd_flags;
  logic       wr_reg, wr_flags;
  logic [3:0] wr_idx;
  logic [3:0] rs1, rs2, rd;
  logic       hazard, live;
  logic [15:0] pending_nxt;
  logic        flags_nxt;

  of_src_decode u_dec (
    .instruction (instruction_in),
    .rd_rs1      (rd_rs1),
    .rd_rs2      (rd_rs2),
    .rd_rd       (rd_rd),
    .rd_ra       (rd_ra),
    .rd_flags    (rd_flags),
    .wr_reg      (wr_reg),
    .wr_idx      (wr_idx),
    .wr_flags    (wr_flags)
  );

  assign rs1 = instruction_in[RS1_HI:RS1_LO];
  assign rs2 = instruction_in[RS2_HI:RS2_LO];
  assign rd  = instruction_in[RD_HI:RD_LO];

  // Hazard from registered state only; a reader waits until the clear has landed.
  always_comb begin
    hazard = (rd_rs1   & pending[rs1])
           | (rd_rs2   & pending[rs2])
           | (rd_rd    & pending[rd])
           | (rd_ra    & pending[RA_IDX])
           | (rd_flags & flags_pending)
           | (wr_reg   & pending[wr_idx])
           | (wr_flags & flags_pending);
  end

  assign live  = inst_valid & ~flush;
  assign stall = live & hazard;
  assign issue = live & ~hazard;

  // Next pending state: write-back clears, issue sets (never the same register).
  always_comb begin
    pending_nxt = pending;
    flags_nxt   = flags_pending;
    if (is_wb)           pending_nxt[wr_adr] = 1'b0;
    if (issue && wr_reg) pending_nxt[wr_idx] = 1'b1;
    if (flags_wb)        flags_nxt = 1'b0;
    if (issue && wr_flags) flags_nxt = 1'b1;
  end

  // Scoreboard state, sticky write-back error and occupancy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= '0;
      flags_pending <= 1'b0;
      busy          <= 1'b0;
      wb_err        <= 1'b0;
    end else begin
      pending       <= pending_nxt;
      flags_pending <= flags_nxt;
      busy          <= (|pending_nxt) | flags_nxt;
      if (is_wb && !pending[wr_adr]) wb_err <= 1'b1;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
  end

endmodule
